// File: rtl/sw_pkg.sv
// Shared switch definitions: packet type, flag polarity and the round-robin pick helper.
package sw_pkg;

    localparam int unsigned PKTW   = 8;
    localparam int unsigned PKT_DW = PKTW + 1;
    localparam int unsigned MAXIN  = 8;

    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    typedef logic [PKT_DW-1:0] pkt_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req searching last+1, last+2, ... modulo n (n in 2..MAXIN).
    function automatic rr_pick_t rr_pick(input logic [MAXIN-1:0] req,
                                         input logic [2:0]       last,
                                         input int unsigned      n);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 1; k <= MAXIN; k++) begin
            j = ({29'd0, last} + k) % n;
            if (k <= n && !res.found && req[j[2:0]]) begin
                res.found = 1'b1;
                res.idx   = j[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Stateless round-robin grant: one-hot gnt and binary idx of the first requester after last.
module rr_arb
    import sw_pkg::*;
#(
    parameter int unsigned NIN = 4
) (
    input  logic [NIN-1:0]         req,
    input  logic [$clog2(NIN)-1:0] last,
    input  logic                   en,
    output logic [NIN-1:0]         gnt,
    output logic [$clog2(NIN)-1:0] idx
);

    localparam int unsigned IW = $clog2(NIN);

    logic [MAXIN-1:0] req_ext;
    logic [2:0]       last_ext;
    rr_pick_t         pick;

    always_comb begin
        req_ext           = '0;
        req_ext[NIN-1:0]  = req;
        last_ext          = 3'(last);
        pick              = rr_pick(req_ext, last_ext, NIN);
    end

    always_comb begin
        gnt = '0;
        idx = pick.idx[IW-1:0];
        if (en && pick.found) begin
            gnt[pick.idx[IW-1:0]] = ASSERT;
        end
    end

endmodule

// File: rtl/sw_out_arb.sv
// Output-port arbiter: round-robin pop from the ingress FIFOs into a registered valid/ready port.
module sw_out_arb
    import sw_pkg::*;
#(
    parameter int unsigned NIN  = 4,
    parameter int unsigned DW   = PKT_DW,
    parameter int unsigned CNTW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NIN*DW-1:0]      fifo_out,
    input  logic [NIN-1:0]         fifo_empty,
    output logic [NIN-1:0]         fifo_re,
    output logic [DW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(NIN)-1:0] grant_idx,
    output logic [CNTW-1:0]        pkt_cnt
);

    localparam int unsigned IW = $clog2(NIN);

    logic [IW-1:0]   rr_last_q, rr_last_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NIN-1:0]  req;
    logic [NIN-1:0]  gnt;
    logic [IW-1:0]   g_idx;
    logic            ld;
    logic            accept;

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            req[i] = (fifo_empty[i] == NEGATE);
        end
    end

    // Load only when the output register is free or draining this cycle.
    assign ld     = (!out_valid_q || out_ready) && (|req);
    assign accept = out_valid_q && out_ready;

    rr_arb #(
        .NIN (NIN)
    ) u_rr_arb (
        .req  (req),
        .last (rr_last_q),
        .en   (ld),
        .gnt  (gnt),
        .idx  (g_idx)
    );

    // rst gates the pop strobes so FIFOs are never popped while the arbiter is held in reset.
    assign fifo_re = gnt & {NIN{ld}} & {NIN{rst}};

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        if (ld) begin
            out_data_d  = fifo_out[g_idx*DW +: DW];
            out_valid_d = 1'b1;
            grant_d     = g_idx;
            rr_last_d   = g_idx;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            rr_last_q   <= IW'(NIN - 1);
            cnt_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_idx = grant_q;
    assign pkt_cnt   = cnt_q;

endmodule
